// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage / cache / SRAM sequencer.
package cache_mem_ctrl_pkg;

  localparam int unsigned LINE_W       = 64;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned WORD_SEL_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line, input logic sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// MEM stage, cache and SRAM-controller signals seen by the sequencer.
interface cache_mem_ctrl_if;
  import cache_mem_ctrl_pkg::*;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [31:0]       mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              freeze;
  logic              cache_hit;
  logic [31:0]       cache_rdata;
  logic              cache_fill;
  logic              cache_wr_upd;
  logic              sram_req;
  logic              sram_we;
  logic [31:0]       sram_adr;
  logic [31:0]       sram_wdata;
  logic [LINE_W-1:0] sram_rdata;
  logic              sram_ready;

  modport slave (
    input  mem_rd_en, mem_wr_en, mem_adr, mem_wdata, cache_hit, cache_rdata,
           sram_rdata, sram_ready,
    output mem_rdata, freeze, cache_fill, cache_wr_upd, sram_req, sram_we,
           sram_adr, sram_wdata
  );

  modport master (
    output mem_rd_en, mem_wr_en, mem_adr, mem_wdata, cache_hit, cache_rdata,
           sram_rdata, sram_ready,
    input  mem_rdata, freeze, cache_fill, cache_wr_upd, sram_req, sram_we,
           sram_adr, sram_wdata
  );

endinterface

// File: rtl/cache_mem_ctrl_sat_counter.sv
// Enable-increment counter that sticks at all-ones; async active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_mem_ctrl.sv
// Sequencer between MEM stage, 2-way read cache and SRAM controller:
// 0-wait read hits, line fill on miss, write-through no-allocate stores, watchdog, statistics.
module cache_mem_ctrl
  import cache_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_mem_ctrl_if.slave  bus,
  output logic             timeout_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [WD_W-1:0]   r_wd;
  logic [31:2]       r_adr;
  logic [31:0]       r_wdata;
  logic              r_timeout_err;

  logic              w_expire;
  logic              w_accept;
  logic              w_freeze;
  logic [31:0]       w_mem_rdata;
  logic              w_cache_fill;
  logic              w_cache_wr_upd;
  logic              w_sram_req;
  logic              w_inc_rd;
  logic              w_inc_hit;
  logic              w_inc_wr;

  // A coinciding sram_ready takes priority over watchdog expiry.
  assign w_expire = (r_state != ST_IDLE) && !bus.sram_ready && (r_wd == WD_W'(TIMEOUT));

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_freeze       = 1'b0;
    w_mem_rdata    = '0;
    w_cache_fill   = 1'b0;
    w_cache_wr_upd = 1'b0;
    w_sram_req     = 1'b0;
    w_inc_rd       = 1'b0;
    w_inc_hit      = 1'b0;
    w_inc_wr       = 1'b0;
    if (rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.mem_wr_en) begin
            w_freeze       = 1'b1;
            w_cache_wr_upd = bus.cache_hit;
            w_accept       = 1'b1;
            w_next         = ST_WR_WAIT;
          end else if (bus.mem_rd_en) begin
            if (bus.cache_hit) begin
              w_mem_rdata = bus.cache_rdata;
              w_inc_rd    = 1'b1;
              w_inc_hit   = 1'b1;
            end else begin
              w_freeze = 1'b1;
              w_accept = 1'b1;
              w_next   = ST_RD_MISS;
            end
          end
        end
        ST_RD_MISS: begin
          if (bus.sram_ready) begin
            w_cache_fill = 1'b1;
            w_mem_rdata  = line_word(bus.sram_rdata, r_adr[WORD_SEL_BIT]);
            w_inc_rd     = 1'b1;
            w_next       = ST_IDLE;
          end else if (w_expire) begin
            w_next = ST_IDLE;
          end else begin
            w_freeze   = 1'b1;
            w_sram_req = 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (bus.sram_ready) begin
            w_inc_wr = 1'b1;
            w_next   = ST_IDLE;
          end else if (w_expire) begin
            w_next = ST_IDLE;
          end else begin
            w_freeze   = 1'b1;
            w_sram_req = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_wd <= '0;
    else if ((r_state == ST_IDLE) || (w_next == ST_IDLE))
      r_wd <= '0;
    else
      r_wd <= r_wd + WD_W'(1);
  end

  // Address/data captured at acceptance so the SRAM side is immune to the MEM stage dropping the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_adr   <= bus.mem_adr[31:2];
      r_wdata <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_timeout_err <= 1'b0;
    else if (w_expire)
      r_timeout_err <= 1'b1;
  end

  assign bus.freeze       = w_freeze;
  assign bus.mem_rdata    = w_mem_rdata;
  assign bus.cache_fill   = w_cache_fill;
  assign bus.cache_wr_upd = w_cache_wr_upd;
  assign bus.sram_req     = w_sram_req;
  assign bus.sram_we      = (r_state == ST_WR_WAIT);
  assign bus.sram_adr     = (r_state == ST_WR_WAIT) ? {r_adr, 2'b00} : {r_adr[31:3], 3'b000};
  assign bus.sram_wdata   = r_wdata;
  assign timeout_err      = r_timeout_err;

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_inc_rd),
    .o_cnt   (rd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_inc_hit),
    .o_cnt   (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_inc_wr),
    .o_cnt   (wr_cnt)
  );

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed plus randomized transactions against a transaction-level model of the sequencer.
module tb_cache_mem_ctrl;

  localparam int unsigned TO   = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          timeout_err;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] wr_cnt;

  cache_mem_ctrl_if bus();

  cache_mem_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timeout_err (timeout_err),
    .rd_cnt      (rd_cnt),
    .hit_cnt     (hit_cnt),
    .wr_cnt      (wr_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned m_rd    = 0;
  int unsigned m_hit   = 0;
  int unsigned m_wr    = 0;
  logic        m_terr  = 1'b0;

  function automatic int unsigned sat(input int unsigned v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.cache_hit   = 1'b0;
    bus.cache_rdata = '0;
    bus.sram_ready  = 1'b0;
    bus.sram_rdata  = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_freeze"}, bus.freeze, 0);
    chk({tag, "_req"}, bus.sram_req, 0);
    chk({tag, "_rdata"}, bus.mem_rdata, 0);
    chk({tag, "_fill"}, bus.cache_fill, 0);
    chk({tag, "_upd"}, bus.cache_wr_upd, 0);
    chk({tag, "_rd_cnt"}, rd_cnt, sat(m_rd));
    chk({tag, "_hit_cnt"}, hit_cnt, sat(m_hit));
    chk({tag, "_wr_cnt"}, wr_cnt, sat(m_wr));
    chk({tag, "_terr"}, timeout_err, m_terr);
  endtask

  task automatic finish_txn(input string tag);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check_idle(tag);
  endtask

  // Read: hit returns in the request cycle; miss waits lat cycles for ready, or TO cycles then aborts.
  task automatic do_read(input logic [31:0] adr, input logic hit, input logic [31:0] crd,
                         input int unsigned lat, input logic [63:0] line, input logic drop);
    int unsigned end_at;
    int unsigned nfrz;
    logic [63:0] sh;
    @(posedge clk); #1;
    bus.mem_rd_en   = 1'b1;
    bus.mem_wr_en   = 1'b0;
    bus.mem_adr     = adr;
    bus.cache_hit   = hit;
    bus.cache_rdata = crd;
    bus.sram_ready  = 1'b0;
    bus.sram_rdata  = line;
    @(negedge clk);
    if (hit) begin
      chk("rd_hit_data", bus.mem_rdata, crd);
      chk("rd_hit_freeze", bus.freeze, 0);
      m_rd++;
      m_hit++;
    end else begin
      chk("rd_miss_freeze0", bus.freeze, 1);
      chk("rd_miss_req0", bus.sram_req, 0);
      nfrz   = 1;
      end_at = (lat < TO) ? lat : TO;
      sh     = line >> (adr[2] ? 32 : 0);
      for (int i = 0; i <= int'(end_at); i++) begin
        @(posedge clk); #1;
        if (drop) bus.mem_rd_en = 1'b0;
        bus.sram_ready = (i == int'(lat));
        @(negedge clk);
        nfrz += int'(bus.freeze);
        if (i < int'(end_at)) begin
          chk("rd_wait_req", bus.sram_req, 1);
          chk("rd_wait_we", bus.sram_we, 0);
          chk("rd_wait_adr", bus.sram_adr, adr & 32'hFFFF_FFF8);
          chk("rd_wait_fill", bus.cache_fill, 0);
        end else if (lat <= TO) begin
          chk("rd_done_fill", bus.cache_fill, 1);
          chk("rd_done_data", bus.mem_rdata, sh[31:0]);
          chk("rd_done_req", bus.sram_req, 0);
          m_rd++;
        end else begin
          chk("rd_to_fill", bus.cache_fill, 0);
          chk("rd_to_data", bus.mem_rdata, 0);
          chk("rd_to_req", bus.sram_req, 0);
          m_terr = 1'b1;
        end
      end
      chk("rd_miss_stall", nfrz, 1 + end_at);
    end
    finish_txn("rd_end");
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] wd, input logic hit,
                          input int unsigned lat, input logic also_rd);
    int unsigned end_at;
    int unsigned nfrz;
    @(posedge clk); #1;
    bus.mem_rd_en   = also_rd;
    bus.mem_wr_en   = 1'b1;
    bus.mem_adr     = adr;
    bus.mem_wdata   = wd;
    bus.cache_hit   = hit;
    bus.cache_rdata = 32'hDEAD_BEEF;
    bus.sram_ready  = 1'b0;
    @(negedge clk);
    chk("wr_freeze0", bus.freeze, 1);
    chk("wr_upd0", bus.cache_wr_upd, hit);
    chk("wr_rdata0", bus.mem_rdata, 0);
    chk("wr_req0", bus.sram_req, 0);
    nfrz   = 1;
    end_at = (lat < TO) ? lat : TO;
    for (int i = 0; i <= int'(end_at); i++) begin
      @(posedge clk); #1;
      bus.sram_ready = (i == int'(lat));
      @(negedge clk);
      nfrz += int'(bus.freeze);
      chk("wr_fill", bus.cache_fill, 0);
      chk("wr_upd", bus.cache_wr_upd, 0);
      if (i < int'(end_at)) begin
        chk("wr_wait_req", bus.sram_req, 1);
        chk("wr_wait_we", bus.sram_we, 1);
        chk("wr_wait_adr", bus.sram_adr, adr & 32'hFFFF_FFFC);
        chk("wr_wait_wdata", bus.sram_wdata, wd);
      end else begin
        chk("wr_done_req", bus.sram_req, 0);
        if (lat <= TO) m_wr++;
        else m_terr = 1'b1;
      end
    end
    chk("wr_stall", nfrz, 1 + end_at);
    finish_txn("wr_end");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] a;
    int unsigned kind;
    int unsigned lat;

    drive_idle();
    bus.mem_adr   = '0;
    bus.mem_wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_freeze", bus.freeze, 0);
    chk("rst_req", bus.sram_req, 0);
    chk("rst_we", bus.sram_we, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    do_read(32'h0000_0040, 1'b1, 32'hCAFE_0001, 0, 64'h0, 1'b0);
    do_read(32'h0000_0104, 1'b0, 32'h0, 4, 64'hAAAA0002_BBBB0001, 1'b0);
    do_write(32'h0000_0020, 32'h55, 1'b1, 3, 1'b0);
    do_write(32'h0000_1000, 32'h77, 1'b0, 2, 1'b0);
    do_write(32'h0000_0044, 32'h99, 1'b1, 1, 1'b1);
    do_read(32'h0000_0200, 1'b0, 32'h0, 0, 64'h1111_2222_3333_4444, 1'b0);
    do_read(32'h0000_0308, 1'b0, 32'h0, TO, 64'h5555_6666_7777_8888, 1'b1);
    do_read(32'h0000_0400, 1'b0, 32'h0, 20, 64'h0, 1'b0);

    // sram_ready while idle must do nothing
    @(posedge clk); #1;
    bus.sram_ready = 1'b1;
    bus.sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check_idle("idle_ready");
    finish_txn("idle_ready_end");

    // reset in the middle of a read miss
    @(posedge clk); #1;
    bus.mem_rd_en = 1'b1;
    bus.mem_adr   = 32'h0000_0500;
    bus.cache_hit = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    m_rd = 0; m_hit = 0; m_wr = 0; m_terr = 1'b0;
    #1;
    chk("mid_rst_req", bus.sram_req, 0);
    chk("mid_rst_freeze", bus.freeze, 0);
    chk("mid_rst_fill", bus.cache_fill, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_rd_cnt", rd_cnt, 0);
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    bus.sram_ready = 1'b1;
    bus.sram_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check_idle("late_ready");
    finish_txn("post_rst");

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      lat  = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 5);
      a    = $urandom;
      if (kind == 0)
        do_read(a, 1'($urandom_range(0, 1)), $urandom, lat,
                {32'($urandom), 32'($urandom)}, ($urandom_range(0, 3) == 0));
      else
        do_write(a, $urandom, 1'($urandom_range(0, 1)), lat, (kind == 2));
    end

    for (int n = 0; n < 18; n++)
      do_read($urandom, 1'b1, $urandom, 0, 64'h0, 1'b0);
    for (int n = 0; n < 18; n++)
      do_write($urandom, $urandom, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
